// File: rtl/trigger_mult_gen.sv
// N-channel FIT trigger generator: per-BC hit accumulation, multiplicity/amplitude triggers
// and a first-word-fall-through event FIFO toward the TCM link.
module trigger_mult_gen #(
    parameter int unsigned NCH        = 12,
    parameter int unsigned PH_W       = 3,
    parameter int unsigned PH_LAST    = 7,
    parameter int unsigned ORBIT_LEN  = 3564,
    parameter int unsigned BCW        = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CW  = $clog2(NCH + 1),
    localparam int unsigned AW  = $clog2(2 * NCH + 1),
    localparam int unsigned EVW = BCW + 2 + CW + AW
) (
    input  logic             clk320,
    input  logic             rst_n,
    input  logic [PH_W-1:0]  mt_cou,
    input  logic [NCH-1:0]   CH_trigt,
    input  logic [NCH-1:0]   CH_triga,
    input  logic [NCH-1:0]   CH_trigb,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [CW-1:0]    thr_t,
    input  logic [AW-1:0]    thr_a,
    output logic             tt,
    output logic             ta,
    output logic [CW-1:0]    n_t,
    output logic [AW-1:0]    amp_sum,
    output logic             tcm_req,
    input  logic             tcm_ack,
    output logic [EVW-1:0]   tcm_data,
    output logic             tcm_ovf
);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW_F = $clog2(FIFO_DEPTH + 1);

    logic [NCH-1:0]  st_t, st_a, st_b;
    logic [NCH-1:0]  in_t, in_a, in_b;
    logic [NCH-1:0]  h_t, h_a, h_b;
    logic            synced;
    logic            eval;
    logic [CW-1:0]   n_t_new;
    logic [AW-1:0]   amp_new;
    logic            tt_new, ta_new;
    logic [BCW-1:0]  bc_id;
    logic [EVW-1:0]  ev_word;

    logic [EVW-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, rd_next;
    logic [CW_F-1:0] count, count_next;
    logic            push, pop, wr_en;
    logic [EVW-1:0]  head_next;

    function automatic logic [AW-1:0] popcnt(input logic [NCH-1:0] v);
        logic [AW-1:0] c;
        c = '0;
        for (int i = 0; i < NCH; i++) c = c + AW'(v[i]);
        return c;
    endfunction

    // Evaluation includes the last-phase input; only full BCs seen since reset are evaluated.
    always_comb begin
        in_t    = CH_trigt & ch_mask;
        in_a    = CH_triga & ch_mask;
        in_b    = CH_trigb & ch_mask;
        h_t     = st_t | in_t;
        h_a     = st_a | in_a;
        h_b     = st_b | in_b;
        eval    = synced && (mt_cou == PH_W'(PH_LAST));
        n_t_new = CW'(popcnt(h_t));
        amp_new = popcnt(h_a) + popcnt(h_b);
        tt_new  = (n_t_new >= thr_t) && (n_t_new != '0);
        ta_new  = (amp_new >= thr_a) && (amp_new != '0);
        ev_word = {bc_id, tt_new, ta_new, n_t_new, amp_new};
    end

    // Next FIFO state and the registered head word (FWFT).
    always_comb begin
        push       = eval && (tt_new || ta_new);
        pop        = tcm_ack && tcm_req;
        wr_en      = push && ((count != CW_F'(FIFO_DEPTH)) || pop);
        rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
        count_next = count;
        if (wr_en && !pop) begin
            count_next = count + CW_F'(1);
        end else if (pop && !wr_en) begin
            count_next = count - CW_F'(1);
        end
        if (count_next == '0) begin
            head_next = '0;
        end else if (wr_en && (wr_ptr == rd_next)) begin
            head_next = ev_word;
        end else begin
            head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk320) begin
        if (!rst_n) begin
            st_t     <= '0;
            st_a     <= '0;
            st_b     <= '0;
            synced   <= 1'b0;
            tt       <= 1'b0;
            ta       <= 1'b0;
            n_t      <= '0;
            amp_sum  <= '0;
            bc_id    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tcm_req  <= 1'b0;
            tcm_data <= '0;
            tcm_ovf  <= 1'b0;
        end else begin
            if (mt_cou == '0) begin
                st_t   <= in_t;
                st_a   <= in_a;
                st_b   <= in_b;
                synced <= 1'b1;
            end else begin
                st_t <= h_t;
                st_a <= h_a;
                st_b <= h_b;
            end
            if (eval) begin
                tt      <= tt_new;
                ta      <= ta_new;
                n_t     <= n_t_new;
                amp_sum <= amp_new;
                bc_id   <= (bc_id == BCW'(ORBIT_LEN - 1)) ? '0 : bc_id + BCW'(1);
            end
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr   <= rd_next;
            count    <= count_next;
            tcm_req  <= (count_next != '0);
            tcm_data <= head_next;
            if (push && !wr_en) tcm_ovf <= 1'b1;
        end
    end

    // Event storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk320) begin
        if (rst_n && wr_en) mem[wr_ptr] <= ev_word;
    end

endmodule

// File: tb/tb_trigger_mult_gen.sv
// Bench for trigger_mult_gen: per-BC vector table, hand sequences for reset/boundary/FIFO/wrap,
// and an event scoreboard compared on every accepted pop.
module tb_trigger_mult_gen;
    localparam int NCH = 12;
    localparam int EVW = 23;
    localparam int FD  = 4;

    logic            clk320 = 1'b0;
    logic            rst_n;
    logic [2:0]      mt_cou;
    logic [NCH-1:0]  CH_trigt, CH_triga, CH_trigb, ch_mask;
    logic [3:0]      thr_t;
    logic [4:0]      thr_a;
    logic            tt, ta, tcm_req, tcm_ack, tcm_ovf;
    logic [3:0]      n_t;
    logic [4:0]      amp_sum;
    logic [EVW-1:0]  tcm_data;

    trigger_mult_gen dut (
        .clk320(clk320), .rst_n(rst_n), .mt_cou(mt_cou),
        .CH_trigt(CH_trigt), .CH_triga(CH_triga), .CH_trigb(CH_trigb),
        .ch_mask(ch_mask), .thr_t(thr_t), .thr_a(thr_a),
        .tt(tt), .ta(ta), .n_t(n_t), .amp_sum(amp_sum),
        .tcm_req(tcm_req), .tcm_ack(tcm_ack), .tcm_data(tcm_data), .tcm_ovf(tcm_ovf)
    );

    always #5 clk320 = ~clk320;

    int checks = 0;
    int failures = 0;

    int             ph = 0;
    int             m_bc = 0;
    logic           m_sync = 1'b0;
    logic [NCH-1:0] m_t = '0, m_a = '0, m_b = '0;
    logic [EVW-1:0] exp_q[$];

    typedef struct {
        int             ph;
        logic [NCH-1:0] t, a, b, mask;
        logic [3:0]     thr_t;
        logic [4:0]     thr_a;
        int             n_t, amp;
        logic           tt, ta, push;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clk320 cycle: drive, update reference model, compare popped head, advance phase.
    task automatic tick(input logic [NCH-1:0] t, input logic [NCH-1:0] a,
                        input logic [NCH-1:0] b, input logic ack);
        logic [NCH-1:0] ht, ha, hb;
        logic           do_pop, do_push, e_tt, e_ta;
        logic [EVW-1:0] word;
        int             nt, am;
        mt_cou = 3'(ph);
        CH_trigt = t; CH_triga = a; CH_trigb = b; tcm_ack = ack;
        do_pop = 1'b0; do_push = 1'b0; word = '0;
        if (rst_n && ack && exp_q.size() != 0) begin
            chk("tcm_data_pop", 32'(tcm_data), 32'(exp_q[0]));
            do_pop = 1'b1;
        end
        if (rst_n && m_sync && ph == 7) begin
            ht = m_t | (t & ch_mask);
            ha = m_a | (a & ch_mask);
            hb = m_b | (b & ch_mask);
            nt = $countones(ht);
            am = $countones(ha) + $countones(hb);
            e_tt = (nt >= int'(thr_t)) && (nt != 0);
            e_ta = (am >= int'(thr_a)) && (am != 0);
            if (e_tt || e_ta) begin
                word = {12'(m_bc), e_tt, e_ta, 4'(nt), 5'(am)};
                if (exp_q.size() < FD || do_pop) do_push = 1'b1;
            end
            m_bc = (m_bc + 1) % 3564;
        end
        if (ph == 0) begin
            m_t = t & ch_mask; m_a = a & ch_mask; m_b = b & ch_mask;
            m_sync = 1'b1;
        end else begin
            m_t |= t & ch_mask; m_a |= a & ch_mask; m_b |= b & ch_mask;
        end
        @(posedge clk320);
        #1;
        if (!rst_n) begin
            m_t = '0; m_a = '0; m_b = '0; m_sync = 1'b0; m_bc = 0;
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(word);
        end
        ph = (ph + 1) % 8;
    endtask

    task automatic idle_to_bc_start();
        do tick('0, '0, '0, 1'b0); while (ph != 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick('0, '0, '0, 1'b0);
        rst_n = 1'b1;
        idle_to_bc_start();
    endtask

    initial begin
        tbl[0] = '{3, 12'h00F, 12'h000, 12'h000, 12'hFFF, 4'd2,  5'd1,  4, 0,  1'b1, 1'b0, 1'b1};
        tbl[1] = '{5, 12'h000, 12'h003, 12'h002, 12'hFFE, 4'd1,  5'd2,  0, 2,  1'b0, 1'b1, 1'b1};
        tbl[2] = '{5, 12'h000, 12'h003, 12'h002, 12'hFFE, 4'd1,  5'd3,  0, 2,  1'b0, 1'b0, 1'b0};
        tbl[3] = '{7, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'd12, 5'd24, 12, 24, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{0, 12'h000, 12'h000, 12'h000, 12'hFFF, 4'd0,  5'd0,  0, 0,  1'b0, 1'b0, 1'b0};
        tbl[5] = '{2, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 4'd1,  5'd1,  0, 0,  1'b0, 1'b0, 1'b0};
        tbl[6] = '{4, 12'hFFF, 12'h000, 12'h800, 12'hFFF, 4'd13, 5'd1,  12, 1, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{0, 12'h010, 12'h000, 12'h000, 12'hFFF, 4'd0,  5'd0,  1, 0,  1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; ch_mask = '1; thr_t = 4'd1; thr_a = 5'd1; tcm_ack = 1'b0;
        CH_trigt = '0; CH_triga = '0; CH_trigb = '0; mt_cou = 3'd3;

        // Reset held at phase 3 with every input high.
        repeat (3) begin
            ph = 3;
            tick('1, '1, '1, 1'b0);
        end
        chk("rst_tt", 32'(tt), 0);
        chk("rst_ta", 32'(ta), 0);
        chk("rst_n_t", 32'(n_t), 0);
        chk("rst_amp", 32'(amp_sum), 0);
        chk("rst_req", 32'(tcm_req), 0);
        chk("rst_data", 32'(tcm_data), 0);
        chk("rst_ovf", 32'(tcm_ovf), 0);
        rst_n = 1'b1;
        ph = 3;
        repeat (5) tick('1, '1, '1, 1'b0);
        chk("partial_bc_tt", 32'(tt), 0);
        chk("partial_bc_n_t", 32'(n_t), 0);
        chk("partial_bc_req", 32'(tcm_req), 0);

        // Multiplicity with a multi-cycle pulse and a last-phase hit.
        thr_t = 4'd3; thr_a = 5'd0; ch_mask = '1;
        for (int p = 0; p < 8; p++) begin
            logic [NCH-1:0] t;
            t = '0;
            if (p == 1) t[0] = 1'b1;
            if (p >= 4 && p <= 6) t[5] = 1'b1;
            if (p == 7) t[11] = 1'b1;
            tick(t, '0, '0, 1'b0);
        end
        chk("mult_n_t", 32'(n_t), 3);
        chk("mult_tt", 32'(tt), 1);
        chk("mult_ta", 32'(ta), 0);
        chk("mult_req", 32'(tcm_req), 1);
        chk("mult_bc_id", 32'(tcm_data[22:11]), 0);
        for (int p = 0; p < 7; p++) begin
            tick('0, '0, '0, p == 0);
            chk("mult_tt_hold", 32'(tt), 1);
        end
        tick('0, '0, '0, 1'b0);
        chk("mult_tt_next", 32'(tt), 0);
        chk("mult_req_popped", 32'(tcm_req), 0);

        // Vector table: one BC per record, ack at phase 0 drains the previous event.
        for (int i = 0; i < 8; i++) begin
            ch_mask = tbl[i].mask; thr_t = tbl[i].thr_t; thr_a = tbl[i].thr_a;
            for (int p = 0; p < 8; p++) begin
                if (p == tbl[i].ph) tick(tbl[i].t, tbl[i].a, tbl[i].b, p == 0);
                else tick('0, '0, '0, p == 0);
            end
            chk($sformatf("tbl%0d_n_t", i), 32'(n_t), 32'(tbl[i].n_t));
            chk($sformatf("tbl%0d_amp", i), 32'(amp_sum), 32'(tbl[i].amp));
            chk($sformatf("tbl%0d_tt", i), 32'(tt), 32'(tbl[i].tt));
            chk($sformatf("tbl%0d_ta", i), 32'(ta), 32'(tbl[i].ta));
            chk($sformatf("tbl%0d_req", i), 32'(tcm_req), 32'(tbl[i].push));
        end

        // Phase-0 hit belongs to the new BC.
        ch_mask = '1; thr_t = 4'd1; thr_a = 5'd0;
        for (int p = 0; p < 8; p++) tick('0, '0, '0, p == 0);
        chk("bnd_bc_k_n_t", 32'(n_t), 0);
        chk("bnd_bc_k_tt", 32'(tt), 0);
        tick(12'h004, '0, '0, 1'b0);
        for (int p = 1; p < 8; p++) tick('0, '0, '0, 1'b0);
        chk("bnd_bc_k1_n_t", 32'(n_t), 1);
        chk("bnd_bc_k1_tt", 32'(tt), 1);

        // FIFO overflow and in-order drain.
        do_reset();
        thr_t = 4'd1; thr_a = 5'd0;
        for (int k = 0; k < 5; k++)
            for (int p = 0; p < 8; p++) tick((p == 2) ? 12'h001 : 12'h000, '0, '0, 1'b0);
        chk("fifo_ovf_set", 32'(tcm_ovf), 1);
        chk("fifo_full_req", 32'(tcm_req), 1);
        for (int k = 0; k < 4; k++) begin
            chk("fifo_order", 32'(tcm_data[22:11]), 32'(k));
            tick('0, '0, '0, 1'b1);
        end
        idle_to_bc_start();
        chk("fifo_drained", 32'(tcm_req), 0);
        chk("fifo_ovf_sticky", 32'(tcm_ovf), 1);

        // Push and pop together while full: no drop, no overflow.
        do_reset();
        for (int k = 0; k < 5; k++)
            for (int p = 0; p < 8; p++)
                tick((p == 2) ? 12'h001 : 12'h000, '0, '0, (k == 4) && (p == 7));
        chk("full_pp_ovf", 32'(tcm_ovf), 0);
        for (int k = 0; k < 4; k++) begin
            chk("full_pp_req", 32'(tcm_req), 1);
            chk("full_pp_order", 32'(tcm_data[22:11]), 32'(k + 1));
            tick('0, '0, '0, 1'b1);
        end
        chk("full_pp_count", 32'(tcm_req), 0);

        // Orbit wrap of bc_id.
        do_reset();
        for (int i = 0; i < 3565; i++) begin
            if (i == 3563) chk("wrap_3562", 32'(tcm_data[22:11]), 3562);
            if (i == 3564) chk("wrap_3563", 32'(tcm_data[22:11]), 3563);
            for (int p = 0; p < 8; p++) tick((p == 0) ? 12'h001 : 12'h000, '0, '0, p == 0);
        end
        chk("wrap_req", 32'(tcm_req), 1);
        chk("wrap_0", 32'(tcm_data[22:11]), 0);
        tick('0, '0, '0, 1'b1);
        chk("wrap_no_ovf", 32'(tcm_ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
